// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: time-multiplexed driver for a four-digit BCD display.
// Each digit is shown for DWELL cycles as a one-hot digit select plus a one-hot
// decimal line. A single pending buffer lets the next value be queued during a frame.
// The queued value is swapped in on the 3->0 digit wrap, so a frame never shows
// a mix of old and new digits.
module bcd_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic        scan_en,
    output logic [3:0]  dig_sel,
    output logic [9:0]  dec_out,
    output logic        code_err,
    output logic        frame_done
);

    localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [15:0]        active;
    logic [15:0]        pending;
    logic               active_valid;
    logic               pending_full;
    logic [1:0]         digit_idx;
    logic [CNT_W-1:0]   dwell_cnt;
    logic               frame_flag;
    logic               accept;
    logic               scanning;
    logic               dwell_last;
    logic               frame_wrap;
    logic [3:0]         nibble;

    // Nibble to {code_err, dec_out}: one-hot for 0..9, error flag for 10..15.
    function automatic logic [10:0] decode_digit(input logic [3:0] nib);
        logic [10:0] res;
        res = '0;
        if (nib > 4'd9) begin
            res[10] = 1'b1;
        end else begin
            res[nib] = 1'b1;
        end
        return res;
    endfunction

    assign accept     = load_valid & ~pending_full;
    assign load_ready = ~pending_full;
    assign scanning   = (state == SCAN) && scan_en;
    assign dwell_last = (dwell_cnt == CNT_LAST);
    assign frame_wrap = scanning && dwell_last && (digit_idx == 2'd3);

    // Next state: start scanning only once there is data to show; any drop of scan_en aborts.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (scan_en && active_valid) state_next = SCAN;
            SCAN:    if (!scan_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Display data: loads go straight to active when idle, otherwise into the pending buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active       <= '0;
            pending      <= '0;
            active_valid <= 1'b0;
            pending_full <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                active       <= load_data;
                active_valid <= 1'b1;
            end else begin
                pending      <= load_data;
                pending_full <= 1'b1;
            end
        end else if (frame_wrap && pending_full) begin
            // accept and this swap are exclusive: accept needs pending_full low.
            active       <= pending;
            pending_full <= 1'b0;
        end
    end

    // Scan position: dwell counter and digit index run only while scanning, else park at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx  <= 2'd0;
            dwell_cnt  <= '0;
            frame_flag <= 1'b0;
        end else if (scanning) begin
            frame_flag <= frame_wrap;
            if (dwell_last) begin
                dwell_cnt <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end else begin
            digit_idx  <= 2'd0;
            dwell_cnt  <= '0;
            frame_flag <= 1'b0;
        end
    end

    // Outputs decoded from registered state only; all quiet when idle.
    always_comb begin
        nibble     = active[{digit_idx, 2'b00} +: 4];
        dig_sel    = 4'b0000;
        dec_out    = 10'b0;
        code_err   = 1'b0;
        frame_done = 1'b0;
        if (state == SCAN) begin
            dig_sel               = 4'b0001 << digit_idx;
            {code_err, dec_out}   = decode_digit(nibble);
            frame_done            = frame_flag;
        end
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Testbench for bcd_scan_ctrl: a DWELL=4 instance and a DWELL=1 instance.
// Expected display cycles are queued by the stimulus; monitors pop one entry
// on every cycle a DUT drives a digit select.
module tb_bcd_scan_ctrl;

    typedef struct packed {
        logic [3:0] ds;
        logic [9:0] dec;
        logic       ce;
        logic       fd;
        logic       rdy;
    } rec_t;

    localparam rec_t IDLE_REC = '{ds: 4'b0, dec: 10'b0, ce: 1'b0, fd: 1'b0, rdy: 1'b1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lv_a, lv_b;
    logic [15:0] ld_a, ld_b;
    logic        se_a, se_b;
    logic        rdy_a, rdy_b;
    logic [3:0]  ds_a, ds_b;
    logic [9:0]  dec_a, dec_b;
    logic        ce_a, ce_b, fd_a, fd_b;
    rec_t        obs_a, obs_b;
    rec_t        qa[$];
    rec_t        qb[$];
    rec_t        exp_a, exp_b;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    bcd_scan_ctrl #(.DWELL(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_valid(lv_a), .load_ready(rdy_a),
        .load_data(ld_a), .scan_en(se_a), .dig_sel(ds_a), .dec_out(dec_a),
        .code_err(ce_a), .frame_done(fd_a)
    );

    bcd_scan_ctrl #(.DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_valid(lv_b), .load_ready(rdy_b),
        .load_data(ld_b), .scan_en(se_b), .dig_sel(ds_b), .dec_out(dec_b),
        .code_err(ce_b), .frame_done(fd_b)
    );

    assign obs_a = {ds_a, dec_a, ce_a, fd_a, rdy_a};
    assign obs_b = {ds_b, dec_b, ce_b, fd_b, rdy_b};

    // Monitor A: every displayed cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (ds_a != 4'b0) begin
            n_vec++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL scan_a: got %h, expected no display", obs_a);
            end else begin
                exp_a = qa.pop_front();
                if (obs_a !== exp_a) begin
                    n_err++;
                    $display("FAIL scan_a @%0t: got %h, expected %h", $time, obs_a, exp_a);
                end
            end
        end
    end

    // Monitor B: same for the DWELL=1 instance.
    always @(negedge clk) begin
        if (ds_b != 4'b0) begin
            n_vec++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL scan_b: got %h, expected no display", obs_b);
            end else begin
                exp_b = qb.pop_front();
                if (obs_b !== exp_b) begin
                    n_err++;
                    $display("FAIL scan_b @%0t: got %h, expected %h", $time, obs_b, exp_b);
                end
            end
        end
    end

    task automatic chk(input string name, input rec_t act, input rec_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // One expected display cycle: digit position, shown value (10..15 = code error).
    task automatic push_rec(input bit which, input int pos, input int val, input bit fd, input bit rdy);
        rec_t r;
        r.ds  = 4'b0001 << pos;
        r.dec = (val <= 9) ? (10'b1 << val) : 10'b0;
        r.ce  = (val > 9);
        r.fd  = fd;
        r.rdy = rdy;
        if (which) qb.push_back(r);
        else       qa.push_back(r);
    endtask

    task automatic push_frame(input bit which, input logic [15:0] d, input int dwell,
                              input bit fd_first, input bit rdy);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < dwell; i++) begin
                push_rec(which, p, int'(d[p*4 +: 4]), fd_first && (p == 0) && (i == 0), rdy);
            end
        end
    endtask

    task automatic load_a(input logic [15:0] d);
        lv_a = 1'b1;
        ld_a = d;
        @(posedge clk); #1;
        lv_a = 1'b0;
    endtask

    // Hold scan_en for k display cycles, then drop it and let the DUT return to idle.
    task automatic run_a(input int k);
        se_a = 1'b1;
        repeat (k) @(posedge clk);
        #1 se_a = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        lv_a = 1'b1; ld_a = 16'h1234; se_a = 1'b1;
        lv_b = 1'b0; ld_b = 16'h0;    se_b = 1'b0;

        // Reset: outputs quiet, ready high, offered load ignored.
        #3 chk("reset_outputs", obs_a, IDLE_REC);
        repeat (3) @(posedge clk);
        #1 chk("reset_hold", obs_a, IDLE_REC);
        lv_a  = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("no_load_during_reset", obs_a, IDLE_REC);
        se_a = 1'b0;
        @(posedge clk); #1;

        // Basic frame of 4321, frame_done on the first cycle of the second frame.
        load_a(16'h4321);
        push_frame(1'b0, 16'h4321, 4, 1'b0, 1'b1);
        push_rec(1'b0, 0, 1, 1'b1, 1'b1);
        run_a(17);
        chk("idle_after_scan", obs_a, IDLE_REC);

        // Invalid code in digit1.
        load_a(16'h00A9);
        push_frame(1'b0, 16'h00A9, 4, 1'b0, 1'b1);
        run_a(16);
        chk("idle_after_err_frame", obs_a, IDLE_REC);

        // Double buffering: 8765 queued at cycle 2, a second offer held but refused.
        load_a(16'h4321);
        for (int c = 1; c <= 33; c++) begin
            push_rec(1'b0, ((c - 1) / 4) % 4,
                     (c <= 16) ? (((c - 1) / 4) % 4) + 1 : (((c - 1) / 4) % 4) + 5,
                     (c == 17) || (c == 33), !((c >= 3) && (c <= 16)));
        end
        se_a = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(posedge clk); #1;
            if (c == 2)  begin lv_a = 1'b1; ld_a = 16'h8765; end
            if (c == 3)  ld_a = 16'h1111;
            if (c == 10) lv_a = 1'b0;
        end
        se_a = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_dbuf", obs_a, IDLE_REC);

        // Abort during digit2, then restart from digit0 without frame_done.
        for (int c = 1; c <= 10; c++) push_rec(1'b0, (c - 1) / 4, ((c - 1) / 4) + 5, 1'b0, 1'b1);
        run_a(10);
        chk("abort_idle", obs_a, IDLE_REC);
        for (int c = 1; c <= 5; c++) push_rec(1'b0, (c - 1) / 4, ((c - 1) / 4) + 5, 1'b0, 1'b1);
        run_a(5);

        // Asynchronous reset mid-frame with pending data queued.
        push_rec(1'b0, 0, 5, 1'b0, 1'b1);
        push_rec(1'b0, 0, 5, 1'b0, 1'b0);
        se_a = 1'b1;
        @(posedge clk); #1;
        lv_a = 1'b1; ld_a = 16'h9999;
        @(posedge clk); #1;
        lv_a = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 chk("reset_async", obs_a, IDLE_REC);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("no_scan_after_reset", obs_a, IDLE_REC);
        se_a = 1'b0;
        @(posedge clk); #1;
        load_a(16'h0246);
        push_frame(1'b0, 16'h0246, 4, 1'b0, 1'b1);
        push_rec(1'b0, 0, 6, 1'b1, 1'b1);
        run_a(17);

        // DWELL=1: new digit every cycle, frame_done every 4th cycle.
        lv_b = 1'b1; ld_b = 16'h9753;
        @(posedge clk); #1;
        lv_b = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            push_rec(1'b1, (c - 1) % 4, 2 * ((c - 1) % 4) + 3, (c == 5) || (c == 9), 1'b1);
        end
        se_b = 1'b1;
        repeat (9) @(posedge clk);
        #1 se_b = 1'b0;
        @(posedge clk); #1;
        chk("idle_b", obs_b, IDLE_REC);

        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d/%0d entries left, expected 0/0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_scan_ctrl.md
BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 4: clock cycles each digit is displayed; legal range 1..256.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port load_valid  input  1  source offers load_data this cycle.
REQ-005 SHALL have port load_ready  output  1  block can accept load_data this cycle.
REQ-006 SHALL have port load_data  input  16  four BCD digits: [3:0] digit0, [7:4] digit1, [11:8] digit2, [15:12] digit3.
REQ-007 SHALL have port scan_en  input  1  level; 1 requests scanning.
REQ-008 SHALL have port dig_sel  output  4  one-hot digit enable; bit n selects digit n.
REQ-009 SHALL have port dec_out  output  10  one-hot decimal line; bit n high when the selected digit equals n.
REQ-010 SHALL have port code_err  output  1  selected digit nibble is 10..15.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-012 SHALL hold a 16-bit active register, an active_valid flag, a 16-bit pending register, and a pending_full flag.
REQ-013 SHALL implement FSM states IDLE and SCAN; all outputs are functions of registered state only (no input-to-output combinational path except none).
REQ-014 Handshake: transfer occurs on a rising edge where load_valid=1 and load_ready=1; load_data needs to be stable only in that cycle.
REQ-015 load_ready SHALL equal NOT pending_full.
REQ-016 In IDLE, an accepted load SHALL write active directly and set active_valid; pending is unchanged.
REQ-017 In SCAN, an accepted load SHALL write pending and set pending_full; the displayed data is unchanged.
REQ-018 IDLE->SCAN on the edge where scan_en=1 and active_valid=1, with digit index 0 and dwell counter 0 at that edge; a load accepted at the same edge counts as an IDLE load (goes to active).
REQ-019 SCAN->IDLE on the first edge where scan_en=0, regardless of position in frame; digit index and dwell counter clear to 0; pending is retained.
REQ-020 In SCAN, the dwell counter SHALL count 0..DWELL-1; at DWELL-1 it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-021 DWELL=1 SHALL advance the digit index every cycle.
REQ-022 At the edge where digit index wraps 3->0: if pending_full, pending SHALL copy to active and pending_full clear at that same edge, so new data shows from the first cycle of digit0.
REQ-023 frame_done SHALL be high for exactly the first cycle of digit0 following a 3->0 wrap; never on the IDLE->SCAN entry cycle and never in IDLE.
REQ-024 In SCAN, dig_sel = one-hot of digit index; the nibble n of the selected digit sets dec_out bit n for n<=9 with code_err=0.
REQ-025 For nibble 10..15, dec_out SHALL be all zero and code_err=1; dig_sel stays asserted.
REQ-026 In IDLE, dig_sel=0, dec_out=0, code_err=0, frame_done=0.

Reset
REQ-027 On rst_n=0, immediately and independent of clk: state IDLE, digit index 0, dwell counter 0, active=0, pending=0, active_valid=0, pending_full=0.
REQ-028 During and after reset: dig_sel=0, dec_out=0, code_err=0, frame_done=0, load_ready=1; no transfer is accepted while rst_n=0.
REQ-029 Reset asserted mid-frame SHALL discard active and pending data; scanning resumes only after a new load and scan_en=1.

Verification
REQ-030 Reset: assert rst_n=0 mid-SCAN between clock edges -> all outputs 0 and load_ready=1 before the next edge.
REQ-031 Basic scan, DWELL=4: load 16'h4321 in IDLE, scan_en=1 -> dig_sel=0001 and dec_out bit1 for 4 cycles, then 0010 with bit2, 0100 with bit3, 1000 with bit4 (4 cycles each); frame_done pulses on cycle 17 with dig_sel=0001.
REQ-032 Invalid code: scan 16'h00A9 -> digit0 dec_out bit9, code_err=0; digit1 dec_out=0, code_err=1; digits 2/3 dec_out bit0.
REQ-033 Double buffering: during frame of 16'h4321, load 16'h8765 -> load_ready low from next cycle, display unchanged; second load_valid held is not accepted; at wrap digit0 shows 5, frame_done=1, load_ready returns to 1 the same cycle.
REQ-034 Abort: drop scan_en during digit2 -> next cycle IDLE with all display outputs 0; re-raise scan_en -> restart at digit0, counter 0, no frame_done.
REQ-035 DWELL=1: digit index advances every cycle; frame_done every 4th cycle.
